// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op helpers for the sequential ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_NOT = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_nbit_comb.sv
// Combinational WIDTH-bit logic/arithmetic slice. Shift codes pass a through
// unchanged so a zero-length shift can reuse this path.
module alu_nbit_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] sum_add;
    logic [WIDTH:0] sum_sub;

    // Subtraction as a + ~b + 1 so carry-out reads as "no borrow".
    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        y        = a;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_NOT: y = ~a;
            OP_ADD: begin
                y        = sum_add[WIDTH-1:0];
                carry    = sum_add[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) & (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                y        = sum_sub[WIDTH-1:0];
                carry    = sum_sub[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) & (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR: y = a ^ b;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/alu_nbit_seq.sv
// Sequential WIDTH-bit ALU: registered result/flags, bit-serial shifter,
// valid/ready handshakes on operand and result sides.
//   state    | meaning
//   ST_IDLE  | in_ready high, waiting for an operand
//   ST_SHIFT | shifting result one bit per cycle, cnt down to terminal count 1
//   ST_DONE  | out_valid high, result held until out_ready
module alu_nbit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state, nstate;
    logic [SHW-1:0]   cnt;
    logic             shr_q;
    logic [SHW-1:0]   shamt;
    logic             start_shift;
    logic [WIDTH-1:0] comb_y;
    logic             comb_c;
    logic             comb_v;
    logic [WIDTH-1:0] shifted;
    logic             shift_out;

    alu_nbit_comb #(.WIDTH(WIDTH)) u_comb (
        .op       (op),
        .a        (a),
        .b        (b),
        .y        (comb_y),
        .carry    (comb_c),
        .overflow (comb_v)
    );

    assign shamt       = b[SHW-1:0];
    assign start_shift = is_shift(op) && (shamt != '0);

    assign shifted   = shr_q ? {1'b0, result[WIDTH-1:1]} : {result[WIDTH-2:0], 1'b0};
    assign shift_out = shr_q ? result[0] : result[WIDTH-1];

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_SHIFT);
    assign out_valid = (state == ST_DONE);

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:  if (in_valid) nstate = start_shift ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (cnt == {{(SHW-1){1'b0}}, 1'b1}) nstate = ST_DONE;
            ST_DONE:  if (out_ready) nstate = ST_IDLE;
            default:  nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nstate;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            shr_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    if (start_shift) begin
                        result   <= a;
                        zero     <= (a == '0);
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                        cnt      <= shamt;
                        shr_q    <= op[0];
                    end else begin
                        result   <= comb_y;
                        zero     <= (comb_y == '0);
                        carry    <= comb_c;
                        overflow <= comb_v;
                    end
                end
                ST_SHIFT: begin
                    result <= shifted;
                    zero   <= (shifted == '0);
                    carry  <= shift_out;
                    cnt    <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
